// File: rtl/pipearch_c1_write_arbiter_if.sv
// Minimal CCI-P c1 channel types plus the requester-side bus of the c1 write arbiter.
// Requesters drive the master modport; the arbiter owns the slave modport.
package pipearch_c1_ccip_pkg;
  typedef logic [511:0] t_ccip_clData;

  localparam logic [1:0] eCL_LEN_1     = 2'b00;
  localparam logic [3:0] eREQ_WRLINE_I = 4'h0;
  localparam logic [3:0] eRSP_WRLINE   = 4'h1;
  localparam logic [3:0] eRSP_WRFENCE  = 4'h4;
  localparam logic [3:0] eRSP_INTR     = 4'h6;

  typedef struct packed {
    logic [5:0]  rsvd2;
    logic [1:0]  vc_sel;
    logic        sop;
    logic        rsvd1;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd0;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_cci_c1_ReqMemHdr;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic        format;
    logic        rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_cci_c1_ReqMemHdr hdr;
    t_ccip_clData      data;
    logic              valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;
endpackage

interface pipearch_c1_write_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]                       req_valid;
  pipearch_c1_ccip_pkg::t_cci_c1_ReqMemHdr  req_hdr  [NUM_REQ];
  pipearch_c1_ccip_pkg::t_ccip_clData       req_data [NUM_REQ];
  logic [NUM_REQ-1:0]                       req_ready;
  logic [NUM_REQ-1:0]                       rsp_valid;

  modport master (output req_valid, req_hdr, req_data, input req_ready, rsp_valid);
  modport slave  (input req_valid, req_hdr, req_data, output req_ready, rsp_valid);
endinterface

// File: rtl/pipearch_c1_write_arbiter.sv
// Round-robin arbiter sharing the CCI-P c1 write channel among NUM_REQ requesters,
// with ack routing and per-requester outstanding counters. Optional: PIPEARCH_C1ARB_CREDIT_EN.
module pipearch_c1_write_arbiter
  import pipearch_c1_ccip_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         c1TxAlmFull,
  pipearch_c1_write_arbiter_if.slave   req_if,
  output t_if_ccip_c1_Tx               af2cp_sTx_c1,
  input  t_if_ccip_c1_Rx               cp2af_sRx_c1,
  output logic                         busy,
  output logic                         err_underflow
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [15:0] OUTST_MAX = 16'hFFFF;

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     next_ptr;
  logic [IDW-1:0]     cand_idx;
  logic [IDW-1:0]     rsp_idx;
  logic               grant_any;
  logic               rsp_is_write;
  logic               any_outst;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ack_vec;
  logic [15:0]        outst [NUM_REQ];

  logic               issue_valid;
  t_cci_c1_ReqMemHdr  issue_hdr;
  t_ccip_clData       issue_data;
  t_cci_c1_ReqMemHdr  tagged_hdr;
  logic               unused_bits;

`ifdef PIPEARCH_C1ARB_CREDIT_EN
  // A requester sitting at its credit limit drops out until an ack frees a slot.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_if.req_valid[i] && (outst[i] != 16'(MAX_OUTSTANDING));
  end
`else
  logic [31:0] unused_max_outstanding;
  assign unused_max_outstanding = 32'(MAX_OUTSTANDING);
  assign eligible = req_if.req_valid;
`endif

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    if (!c1TxAlmFull) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand_idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
        if (!grant_any && eligible[cand_idx]) begin
          grant_any = 1'b1;
          grant_idx = cand_idx;
        end
      end
    end
  end

  assign grant            = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
  assign next_ptr         = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign req_if.req_ready = grant;

  // The tag field carries the issuer index so the ack can find its way home.
  always_comb begin
    tagged_hdr = req_if.req_hdr[grant_idx];
    tagged_hdr.mdata[15 -: IDW] = grant_idx;
  end

  assign rsp_idx      = cp2af_sRx_c1.hdr.mdata[15 -: IDW];
  assign rsp_is_write = cp2af_sRx_c1.rspValid && (cp2af_sRx_c1.hdr.resp_type == eRSP_WRLINE);

  always_comb begin
    ack_vec = '0;
    if (rsp_is_write && (int'(rsp_idx) < NUM_REQ))
      ack_vec[rsp_idx] = 1'b1;
  end

  always_comb begin
    any_outst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      any_outst = any_outst | (outst[i] != 16'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      issue_valid <= grant_any;
      if (grant_any)
        rr_ptr <= next_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_any) begin
      issue_hdr  <= tagged_hdr;
      issue_data <= req_if.req_data[grant_idx];
    end
  end

  always_comb begin
    af2cp_sTx_c1       = '0;
    af2cp_sTx_c1.valid = issue_valid;
    af2cp_sTx_c1.hdr   = issue_hdr;
    af2cp_sTx_c1.data  = issue_data;
  end

  // A grant and an ack to the same requester in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++)
        outst[i] <= '0;
      req_if.rsp_valid <= '0;
      busy             <= 1'b0;
      err_underflow    <= 1'b0;
    end else begin
      req_if.rsp_valid <= ack_vec;
      busy             <= any_outst;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && !ack_vec[i]) begin
          if (outst[i] != OUTST_MAX)
            outst[i] <= outst[i] + 16'd1;
        end else if (ack_vec[i] && !grant[i]) begin
          if (outst[i] == 16'd0)
            err_underflow <= 1'b1;
          else
            outst[i] <= outst[i] - 16'd1;
        end
      end
    end
  end

  always_comb begin
    unused_bits = ^{cp2af_sRx_c1.hdr.vc_used, cp2af_sRx_c1.hdr.rsvd1, cp2af_sRx_c1.hdr.hit_miss,
                    cp2af_sRx_c1.hdr.format, cp2af_sRx_c1.hdr.rsvd0, cp2af_sRx_c1.hdr.cl_num,
                    cp2af_sRx_c1.hdr.mdata[15-IDW:0]};
    for (int i = 0; i < NUM_REQ; i++)
      unused_bits = unused_bits ^ (^req_if.req_hdr[i].mdata[15 -: IDW]);
  end
endmodule

// File: tb/tb_pipearch_c1_write_arbiter.sv
// Self-checking bench for pipearch_c1_write_arbiter: vector table, directed corner sequences,
// and randomized traffic against a behavioural model of arbitration and outstanding counts.
module tb_pipearch_c1_write_arbiter;
  import pipearch_c1_ccip_pkg::*;

  localparam int NR = 4;
`ifdef PIPEARCH_C1ARB_CREDIT_EN
  localparam int MAXO = 2;
  localparam bit CREDIT_ON = 1'b1;
`else
  localparam int MAXO = 64;
  localparam bit CREDIT_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           alm;
  t_if_ccip_c1_Tx tx;
  t_if_ccip_c1_Rx rx;
  logic           busy;
  logic           err;

  logic           alm3;
  t_if_ccip_c1_Tx tx3;
  t_if_ccip_c1_Rx rx3;
  logic           busy3;
  logic           err3;

  pipearch_c1_write_arbiter_if #(.NUM_REQ(NR)) rif ();
  pipearch_c1_write_arbiter_if #(.NUM_REQ(3))  rif3 ();

  pipearch_c1_write_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .c1TxAlmFull(alm), .req_if(rif.slave),
    .af2cp_sTx_c1(tx), .cp2af_sRx_c1(rx), .busy(busy), .err_underflow(err));

  // Non-power-of-two instance: tag value 3 is out of range and must be dropped.
  pipearch_c1_write_arbiter #(.NUM_REQ(3), .MAX_OUTSTANDING(MAXO)) dut3 (
    .clk(clk), .reset(reset), .c1TxAlmFull(alm3), .req_if(rif3.slave),
    .af2cp_sTx_c1(tx3), .cp2af_sRx_c1(rx3), .busy(busy3), .err_underflow(err3));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_ptr;
  int m_outst [NR];
  bit m_err;

  typedef struct {
    logic [NR-1:0] rv;
    bit            af;
    bit            ackv;
    logic [3:0]    atype;
    int            atag;
    logic [NR-1:0] exp_ready;
  } vec_t;
  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void addVec(input logic [NR-1:0] rv, input bit af, input bit ackv,
                                 input logic [3:0] atype, input int atag, input logic [NR-1:0] er);
    vec_t v;
    v.rv = rv; v.af = af; v.ackv = ackv; v.atype = atype; v.atag = atag; v.exp_ready = er;
    vecs.push_back(v);
  endfunction

  function automatic int modelPick(input logic [NR-1:0] rv, input bit af);
    int i;
    if (af) return -1;
    for (int k = 0; k < NR; k++) begin
      i = (m_ptr + k) % NR;
      if (rv[i] && (!CREDIT_ON || m_outst[i] < MAXO)) return i;
    end
    return -1;
  endfunction

  // One clock of stimulus; the model predicts grant, issue, ack routing and counters.
  task automatic applyStimulus(input logic [NR-1:0] rv, input bit af, input bit ackv,
                               input logic [3:0] atype, input int atag, output logic [NR-1:0] got);
    t_cci_c1_ReqMemHdr h;
    t_ccip_clData      d;
    t_cci_c1_ReqMemHdr exp_hdr;
    t_ccip_clData      exp_data;
    int gidx, ack_i;
    bit exp_busy, g, a;
    logic [NR-1:0] exp_ready, exp_rsp;
    for (int i = 0; i < NR; i++) begin
      h = '0;
      h.address  = {10'($urandom), $urandom};
      h.mdata    = 16'($urandom);
      h.req_type = eREQ_WRLINE_I;
      h.cl_len   = eCL_LEN_1;
      h.sop      = 1'b1;
      for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
      rif.req_hdr[i]  = h;
      rif.req_data[i] = d;
    end
    rif.req_valid = rv;
    alm = af;
    rx = '0;
    rx.rspValid = ackv;
    rx.hdr.resp_type = atype;
    rx.hdr.mdata = {2'(atag), 14'($urandom)};
    #1;
    gidx = modelPick(rv, af);
    exp_ready = (gidx >= 0) ? NR'(1 << gidx) : '0;
    checkOutput("req_ready", rif.req_ready, exp_ready);
    got = rif.req_ready;
    exp_hdr = '0;
    exp_data = '0;
    if (gidx >= 0) begin
      exp_hdr = rif.req_hdr[gidx];
      exp_hdr.mdata[15:14] = 2'(gidx);
      exp_data = rif.req_data[gidx];
    end
    ack_i = (ackv && atype == eRSP_WRLINE) ? atag : -1;
    exp_rsp = (ack_i >= 0) ? NR'(1 << ack_i) : '0;
    @(posedge clk);
    #1;
    exp_busy = 1'b0;
    for (int i = 0; i < NR; i++) if (m_outst[i] != 0) exp_busy = 1'b1;
    for (int i = 0; i < NR; i++) begin
      g = (i == gidx);
      a = (i == ack_i);
      if (g && !a) begin
        if (m_outst[i] < 65535) m_outst[i]++;
      end else if (a && !g) begin
        if (m_outst[i] == 0) m_err = 1'b1;
        else m_outst[i]--;
      end
    end
    if (gidx >= 0) m_ptr = (gidx + 1) % NR;
    checkOutput("tx_valid", tx.valid, gidx >= 0);
    if (gidx >= 0) begin
      checkOutput("tx_hdr", tx.hdr, exp_hdr);
      checkOutput("tx_data", tx.data, exp_data);
    end
    checkOutput("rsp_valid", rif.rsp_valid, exp_rsp);
    checkOutput("busy", busy, exp_busy);
    checkOutput("err_underflow", err, m_err);
    @(negedge clk);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    rif.req_valid = '0;
    alm = 1'b0;
    rx = '0;
    @(posedge clk);
    #1;
    checkOutput("rst_tx_valid", tx.valid, 1'b0);
    checkOutput("rst_rsp_valid", rif.rsp_valid, '0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_req_ready", rif.req_ready, '0);
    m_ptr = 0;
    m_err = 1'b0;
    for (int i = 0; i < NR; i++) m_outst[i] = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkCounters(input int c0, input int c1, input int c2, input int c3);
    int e [NR];
    e = '{c0, c1, c2, c3};
    for (int i = 0; i < NR; i++) checkOutput($sformatf("outst[%0d]", i), dut.outst[i], 16'(e[i]));
  endtask

  task automatic checkModelCounters();
    for (int i = 0; i < NR; i++) checkOutput($sformatf("model_outst[%0d]", i), dut.outst[i], 16'(m_outst[i]));
  endtask

  initial begin
    logic [NR-1:0] got;
    int cnt, n2, nw, tag, r;
    logic [3:0] ty;

    reset = 1'b1;
    alm = 1'b0;
    alm3 = 1'b0;
    rx = '0;
    rx3 = '0;
    rif.req_valid = '0;
    rif3.req_valid = '0;
    rif3.req_hdr = '{default: '0};
    rif3.req_data = '{default: '0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetDut();

    // Out-of-range tag on the 3-requester instance is dropped; tag 2 routes.
    rx3.rspValid = 1'b1;
    rx3.hdr.resp_type = eRSP_WRLINE;
    rx3.hdr.mdata = {2'd3, 14'h1234};
    @(posedge clk); #1;
    checkOutput("n3_drop_rsp", rif3.rsp_valid, 3'b000);
    checkOutput("n3_drop_err", err3, 1'b0);
    @(negedge clk);
    rx3.hdr.mdata = {2'd2, 14'h0042};
    @(posedge clk); #1;
    checkOutput("n3_route_rsp", rif3.rsp_valid, 3'b100);
    checkOutput("n3_route_err", err3, 1'b1);
    @(negedge clk);
    rx3 = '0;

    n2 = CREDIT_ON ? 2 : 5;
    for (int i = 0; i < 8; i++) addVec(4'hF, 1'b0, 1'b0, 4'h0, 0, NR'(1 << (i % 4)));
    addVec(4'h4, 1'b0, 1'b0, 4'h0, 0, CREDIT_ON ? 4'h0 : 4'h4);
    for (int i = 0; i < 3; i++) addVec(4'h4, 1'b1, 1'b0, 4'h0, 0, 4'h0);
    for (int i = 0; i < 2; i++) addVec(4'h4, 1'b0, 1'b0, 4'h0, 0, CREDIT_ON ? 4'h0 : 4'h4);
    for (int i = 0; i < 2; i++) addVec(4'h0, 1'b0, 1'b1, eRSP_WRLINE, 0, 4'h0);
    for (int i = 0; i < 2; i++) addVec(4'h0, 1'b0, 1'b1, eRSP_WRLINE, 1, 4'h0);
    for (int i = 0; i < 2; i++) addVec(4'h0, 1'b0, 1'b1, eRSP_WRLINE, 3, 4'h0);
    for (int i = 0; i < n2; i++) addVec(4'h0, 1'b0, 1'b1, eRSP_WRLINE, 2, 4'h0);
    addVec(4'h0, 1'b0, 1'b1, eRSP_WRFENCE, 0, 4'h0);
    for (int i = 0; i < 2; i++) addVec(4'h0, 1'b0, 1'b0, 4'h0, 0, 4'h0);

    foreach (vecs[n]) begin
      if (n == 8) checkCounters(2, 2, 2, 2);
      applyStimulus(vecs[n].rv, vecs[n].af, vecs[n].ackv, vecs[n].atype, vecs[n].atag, got);
      checkOutput($sformatf("tbl_ready[%0d]", n), got, vecs[n].exp_ready);
    end
    checkCounters(0, 0, 0, 0);

    // Requester 1: a burst of writes, then the matching acks.
    nw = CREDIT_ON ? 2 : 3;
    for (int i = 0; i < nw; i++) applyStimulus(4'h2, 1'b0, 1'b0, 4'h0, 0, got);
    cnt = 0;
    for (int i = 0; i < nw; i++) begin
      applyStimulus(4'h0, 1'b0, 1'b1, eRSP_WRLINE, 1, got);
      if (rif.rsp_valid[1]) cnt++;
    end
    checkOutput("req1_pulses", cnt, nw);
    checkOutput("req1_busy_lag", busy, 1'b1);
    applyStimulus(4'h0, 1'b0, 1'b0, 4'h0, 0, got);
    checkOutput("req1_busy_fall", busy, 1'b0);
    checkCounters(0, 0, 0, 0);

    // Simultaneous grant and ack on requester 0, then underflow.
    applyStimulus(4'h1, 1'b0, 1'b0, 4'h0, 0, got);
    applyStimulus(4'h1, 1'b0, 1'b1, eRSP_WRLINE, 0, got);
    checkOutput("same_cycle_rsp", rif.rsp_valid, 4'h1);
    checkCounters(1, 0, 0, 0);
    applyStimulus(4'h0, 1'b0, 1'b1, eRSP_WRLINE, 0, got);
    checkOutput("pre_underflow_err", err, 1'b0);
    applyStimulus(4'h0, 1'b0, 1'b1, eRSP_WRLINE, 0, got);
    checkOutput("underflow_err", err, 1'b1);
    applyStimulus(4'h0, 1'b0, 1'b0, 4'h0, 0, got);
    checkOutput("underflow_sticky", err, 1'b1);

`ifdef PIPEARCH_C1ARB_CREDIT_EN
    resetDut();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'h8, 1'b0, 1'b0, 4'h0, 0, got);
      if (got[3]) cnt++;
    end
    checkOutput("credit_grants", cnt, 2);
    applyStimulus(4'h8, 1'b0, 1'b1, eRSP_WRLINE, 3, got);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'h8, 1'b0, 1'b0, 4'h0, 0, got);
      if (got[3]) cnt++;
    end
    checkOutput("credit_regrant", cnt, 1);
`endif

    // Reset landing in the middle of traffic.
    resetDut();
    applyStimulus(4'hD, 1'b0, 1'b0, 4'h0, 0, got);
    applyStimulus(4'hD, 1'b0, 1'b0, 4'h0, 0, got);
    applyStimulus(4'hD, 1'b0, 1'b0, 4'h0, 0, got);
    for (int i = 0; i < 4; i++) applyStimulus(4'h5, 1'b0, 1'b0, 4'h0, 0, got);
    for (int i = 0; i < 2; i++) applyStimulus(4'h1, 1'b0, 1'b0, 4'h0, 0, got);
    checkModelCounters();
`ifndef PIPEARCH_C1ARB_CREDIT_EN
    checkCounters(5, 0, 3, 1);
`endif
    resetDut();
    checkCounters(0, 0, 0, 0);
    applyStimulus(4'hF, 1'b0, 1'b0, 4'h0, 0, got);
    checkOutput("post_reset_ptr", got, 4'h1);

    // Randomized traffic against the model.
    resetDut();
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 9));
      ty = (r < 6) ? eRSP_WRLINE : (r < 8) ? eRSP_WRFENCE : eRSP_INTR;
      tag = int'($urandom_range(0, NR - 1));
      applyStimulus(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1, ty, tag, got);
      if (n % 100 == 99) checkModelCounters();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
